// File: rtl/score_frame_tx.sv
// Inter-board score link transmitter: frames {SYNC, board_ID, points} onto a valid/ready byte port.
// Define SCORE_TX_CHECKSUM_EN to append an XOR checksum byte (6-byte frame instead of 5).
module score_frame_tx #(
  parameter int unsigned REFRESH_CYCLES = 6_500_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [7:0]  board_ID,
  input  logic [23:0] points,
  input  logic        send_now,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);

`ifdef SCORE_TX_CHECKSUM_EN
  localparam int unsigned NumBytes = 6;
`else
  localparam int unsigned NumBytes = 5;
`endif
  localparam int unsigned      TimerW    = $clog2(REFRESH_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(REFRESH_CYCLES - 1);
  localparam logic [2:0]        LastIdx   = 3'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pending_q, pending_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        id_q;
  logic [23:0]       pts_q;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        byte_sel;
  logic              trigger, handshake, last_hs;

  assign trigger   = send_now | (timer_q == TimerLast);
  assign timer_d   = (timer_q == TimerLast) ? '0 : timer_q + 1'b1;
  assign handshake = tx_valid_q & tx_ready;
  assign last_hs   = handshake & (idx_q == LastIdx);
  // LOAD consumes the flag, but a trigger in that same cycle re-arms it.
  assign pending_d = trigger | (pending_q & (state_q != StLoad));

`ifdef SCORE_TX_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (state_q == StLoad) begin
      chk_q <= board_ID ^ points[23:16] ^ points[15:8] ^ points[7:0];
    end
  end
`endif

  // State register and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      idx_q       <= '0;
      id_q        <= '0;
      pts_q       <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      if (state_q == StLoad) begin
        id_q  <= board_ID;
        pts_q <= points;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (pending_d) state_d = StLoad;
      end
      StLoad: begin
        state_d = StSend;
        idx_d   = '0;
      end
      StSend: begin
        if (handshake) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte for the next cycle, chosen from the index being entered
  always_comb begin
    case (idx_d)
      3'd0:    byte_sel = SYNC_BYTE;
      3'd1:    byte_sel = id_q;
      3'd2:    byte_sel = pts_q[23:16];
      3'd3:    byte_sel = pts_q[15:8];
      3'd4:    byte_sel = pts_q[7:0];
`ifdef SCORE_TX_CHECKSUM_EN
      3'd5:    byte_sel = chk_q;
`endif
      default: byte_sel = '0;
    endcase
  end

  // Output next-values; registered above so tx_ready never reaches a port combinationally
  always_comb begin
    tx_valid_d  = (state_d == StSend);
    busy_d      = (state_d != StIdle);
    frame_cnt_d = frame_cnt_q + {15'd0, last_hs};
    tx_byte_d   = tx_valid_d ? byte_sel : tx_byte_q;
  end

  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_score_frame_tx.sv
// Bench for score_frame_tx: frame-level reference model plus directed hand-computed checks.
// Instance a uses a long refresh period (send_now driven); instance b a 20-cycle period.
module tb_score_frame_tx;

  localparam int unsigned RA   = 1000;
  localparam int unsigned RB   = 20;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef SCORE_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  board_ID;
  logic [23:0] points;
  logic        send_now, send_now_b, tx_ready;
  logic [7:0]  tx_byte_a, tx_byte_b;
  logic        tx_valid_a, tx_valid_b, busy_a, busy_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  score_frame_tx #(.REFRESH_CYCLES(RA), .SYNC_BYTE(SYNC)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .board_ID(board_ID), .points(points), .send_now(send_now),
    .tx_byte(tx_byte_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready), .busy(busy_a),
    .frame_cnt(frame_cnt_a)
  );

  score_frame_tx #(.REFRESH_CYCLES(RB), .SYNC_BYTE(SYNC)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .board_ID(board_ID), .points(points), .send_now(send_now_b),
    .tx_byte(tx_byte_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready), .busy(busy_b),
    .frame_cnt(frame_cnt_b)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 sending; frame held as a byte list.
  int          m_phase [2];
  bit          m_pend  [2];
  int unsigned m_timer [2];
  int          m_idx   [2];
  logic [7:0]  m_frame [2][6];
  logic [15:0] m_cnt   [2];
  bit          m_trig;
  int          m_prev;
  int unsigned m_rc;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_pend[k] = 0; m_timer[k] = 0; m_idx[k] = 0; m_cnt[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rc   = (k == 0) ? RA : RB;
        m_trig = ((k == 0) ? send_now : send_now_b) || (m_timer[k] == m_rc - 1);
        m_timer[k] = (m_timer[k] + 1) % m_rc;
        m_prev = m_phase[k];
        m_pend[k] = (m_prev == 1) ? m_trig : (m_pend[k] | m_trig);
        if (m_prev == 0) begin
          if (m_pend[k]) m_phase[k] = 1;
        end else if (m_prev == 1) begin
          m_frame[k][0] = SYNC;
          m_frame[k][1] = board_ID;
          m_frame[k][2] = points[23:16];
          m_frame[k][3] = points[15:8];
          m_frame[k][4] = points[7:0];
          m_frame[k][5] = m_frame[k][1] ^ m_frame[k][2] ^ m_frame[k][3] ^ m_frame[k][4];
          m_idx[k] = 0;
          m_phase[k] = 2;
        end else if (tx_ready) begin
          if (m_idx[k] == NB - 1) begin
            m_phase[k] = 0;
            m_idx[k] = 0;
            m_cnt[k] = m_cnt[k] + 16'd1;
          end else begin
            m_idx[k] = m_idx[k] + 1;
          end
        end
      end
    end
  end

  task automatic cmp_dut(input string tag, input int k, input logic v, input logic [7:0] b,
                         input logic bz, input logic [15:0] c);
    check({tag, "_valid"}, v, m_phase[k] == 2);
    check({tag, "_busy"}, bz, m_phase[k] != 0);
    check({tag, "_cnt"}, c, m_cnt[k]);
    if (m_phase[k] == 2) check({tag, "_byte"}, b, m_frame[k][m_idx[k]]);
  endtask

  always @(negedge pclk) begin
    if (rst_n === 1'b1) begin
      cmp_dut("model_a", 0, tx_valid_a, tx_byte_a, busy_a, frame_cnt_a);
      cmp_dut("model_b", 1, tx_valid_b, tx_byte_b, busy_b, frame_cnt_b);
    end
  end

  task automatic pulse_send();
    send_now = 1'b1;
    @(negedge pclk);
    send_now = 1'b0;
  endtask

  task automatic wait_b_start(output bit ok, output int at);
    logic prev;
    ok = 1'b0;
    at = 0;
    prev = tx_valid_b;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge pclk);
      if (!prev && tx_valid_b) begin
        ok = 1'b1;
        at = cyc;
      end
      prev = tx_valid_b;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp1 [6];
  logic       exp_v;
  bit         ok;
  int         t0, t1;

  initial begin
    exp1 = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h24};
    send_now = 0; send_now_b = 0; tx_ready = 1;
    board_ID = 8'h02; points = 24'h001234;
    repeat (2) @(negedge pclk);
    check("rst_byte", tx_byte_a, 8'h00);
    check("rst_valid", tx_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_cnt", frame_cnt_a, 16'h0000);
    #2 rst_n = 1'b1;

    // Single frame: send_now in cycle 10, bytes in 12..(11+NB)
    repeat (10) @(negedge pclk);
    pulse_send();
    check("single_load_busy", busy_a, 1'b1);
    check("single_load_valid", tx_valid_a, 1'b0);
    for (int i = 0; i < NB; i++) begin
      @(negedge pclk);
      check("single_valid", tx_valid_a, 1'b1);
      check("single_byte", tx_byte_a, exp1[i]);
    end
    @(negedge pclk);
    check("single_end_busy", busy_a, 1'b0);
    check("single_end_valid", tx_valid_a, 1'b0);
    check("single_end_cnt", frame_cnt_a, 16'd1);

    // Backpressure on byte index 2
    repeat (3) @(negedge pclk);
    pulse_send();
    repeat (3) @(negedge pclk);
    tx_ready = 1'b0;
    check("bp_byte", tx_byte_a, 8'h00);
    repeat (3) begin
      @(negedge pclk);
      check("bp_hold_valid", tx_valid_a, 1'b1);
      check("bp_hold_byte", tx_byte_a, 8'h00);
    end
    tx_ready = 1'b1;
    @(negedge pclk);
    check("bp_next_byte", tx_byte_a, 8'h12);
    repeat (NB - 3) @(negedge pclk);
    check("bp_end_busy", busy_a, 1'b0);
    check("bp_end_cnt", frame_cnt_a, 16'd2);

    // Coalescing: pulses in cycles 2, 4, 6 of a frame give exactly one more frame
    repeat (3) @(negedge pclk);
    pulse_send();
    @(negedge pclk);
    pulse_send();
    @(negedge pclk);
    pulse_send();
    @(negedge pclk);
    pulse_send();
    for (int k = 7; k <= 2 * NB + 4; k++) begin
      if (k > 7) @(negedge pclk);
      exp_v = (k <= NB + 1) || (k >= NB + 4 && k <= 2 * NB + 3);
      check("coal_valid", tx_valid_a, exp_v);
      if (k == NB + 4) check("coal_second_sync", tx_byte_a, SYNC);
    end
    check("coal_cnt", frame_cnt_a, 16'd4);
    repeat (10) begin
      @(negedge pclk);
      check("coal_no_third", busy_a, 1'b0);
    end

    // Reset mid-frame
    pulse_send();
    repeat (2) @(negedge pclk);
    check("prerst_valid", tx_valid_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_byte", tx_byte_a, 8'h00);
    check("arst_valid", tx_valid_a, 1'b0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_cnt", frame_cnt_a, 16'h0000);
    check("arst_b_valid", tx_valid_b, 1'b0);
    @(negedge pclk);
    #2 rst_n = 1'b1;
    repeat (15) begin
      @(negedge pclk);
      check("post_rst_idle", tx_valid_a, 1'b0);
    end

    // frame_cnt wrap
    #2 force dut_a.frame_cnt_q = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    #1 release dut_a.frame_cnt_q;
    @(negedge pclk);
    check("force_applied", frame_cnt_a, 16'hFFFF);
    pulse_send();
    repeat (NB + 1) @(negedge pclk);
    check("cnt_wrap", frame_cnt_a, 16'h0000);
    check("wrap_busy", busy_a, 1'b0);

    // Timer-driven frames on instance b; points change after its LOAD
    wait_b_start(ok, t0);
    check("timer_start_found", ok, 1'b1);
    check("timer_first_sync", tx_byte_b, SYNC);
    points = 24'h005678;
    repeat (4) @(negedge pclk);
    check("timer_old_points", tx_byte_b, 8'h34);
    wait_b_start(ok, t1);
    check("timer_next_found", ok, 1'b1);
    check("timer_period", t1 - t0, 20);
    repeat (4) @(negedge pclk);
    check("timer_new_points", tx_byte_b, 8'h78);
    repeat (NB) @(negedge pclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
